// File: rtl/rr_arbiter_8.sv
// ---------------------------------------------------------------------------
// rr_arbiter_8
//
// Round-robin arbiter sharing one resource among eight requesters.
// A two-state machine (IDLE / GRANT) picks a winner in IDLE by scanning the
// request vector starting at a rotating priority pointer. It then holds the
// grant until the owner drops its request or the hold limit expires. Every
// handover passes through exactly one IDLE cycle.
//
// Parameters
//   MAX_HOLD   maximum consecutive GRANT cycles per owner (0 = unlimited,
//              legal range 0..255)
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   req[7:0]   level-sensitive request vector, bit i = requester i
//   gnt[7:0]   registered one-hot grant, all-zero when there is no owner
//   gnt_id     binary index of the current owner (meaningful when gnt_valid)
//   gnt_valid  high while a grant is active
// ---------------------------------------------------------------------------
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT   = 8'hFF;

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_hold;
    logic [7:0] r_gnt;
    logic [2:0] r_gnt_id;
    logic       r_gnt_valid;

    logic [7:0] w_rot;       // requests rotated so that bit 0 is req[r_ptr]
    logic [2:0] w_offset;    // distance of the winner from r_ptr
    logic       w_any;
    logic [2:0] w_winner;
    logic [7:0] w_dec;       // 3-to-8 decode of w_winner
    logic       w_owner_req;
    logic       w_timeout;
    logic       w_release;

    // Rotate the request vector so a plain lowest-set-bit search from bit 0
    // is equivalent to scanning ptr, ptr+1, ..., ptr+7 modulo 8.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            logic [2:0] w_src;
            assign w_src     = r_ptr + 3'(gi);
            assign w_rot[gi] = req[w_src];
        end
    endgenerate

    // Lowest set bit of the rotated vector; scanning from the top down lets
    // the last assignment (lowest index) win without a found flag.
    always_comb begin
        w_offset = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_offset = 3'(k);
            end
        end
    end

    assign w_any    = |req;
    assign w_winner = r_ptr + w_offset;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign w_dec[gi] = (w_winner == 3'(gi));
        end
    endgenerate

    // Release when the owner lets go, or when a finite hold limit is reached.
    assign w_owner_req = req[r_gnt_id];
    assign w_timeout   = (MAX_HOLD != 0) && (r_hold == HOLD_LIMIT);
    assign w_release   = !w_owner_req || w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_ptr       <= 3'd0;
            r_hold      <= 8'd0;
            r_gnt       <= 8'd0;
            r_gnt_id    <= 3'd0;
            r_gnt_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= GRANT;
                        r_gnt_id    <= w_winner;
                        r_gnt       <= w_dec;
                        r_gnt_valid <= 1'b1;
                        r_hold      <= 8'd1;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        // gnt_id keeps its last value; the pointer moves past
                        // the owner so a timed-out owner goes to the back.
                        r_state     <= IDLE;
                        r_gnt       <= 8'd0;
                        r_gnt_valid <= 1'b0;
                        r_ptr       <= r_gnt_id + 3'd1;
                        r_hold      <= 8'd0;
                    end else if (r_hold != HOLD_SAT) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;

endmodule
